// File: rtl/pla_t4_eval_sched_if.sv
// Purpose: request/PLA/response bundle for pla_t4_eval_sched.
// Ports:   req_valid/req_ready/req_x (per-requester), pla_x/pla_z (external PLA),
//          rsp_valid/rsp_ready/rsp_id/rsp_z (response channel), busy.
interface pla_t4_eval_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*12-1:0] req_x;
  logic [11:0]           pla_x;
  logic [7:0]            pla_z;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [7:0]            rsp_z;
  logic                  busy;

  // Scheduler side.
  modport slave (
    input  req_valid, req_x, pla_z, rsp_ready,
    output req_ready, pla_x, rsp_valid, rsp_id, rsp_z, busy
  );

  // Environment side: requesters, PLA and response consumer.
  modport master (
    output req_valid, req_x, pla_z, rsp_ready,
    input  req_ready, pla_x, rsp_valid, rsp_id, rsp_z, busy
  );
endinterface

// File: rtl/pla_t4_eval_sched.sv
// Purpose: time-shares one external 12-in/8-out PLA between NUM_REQ requesters,
//          round-robin arbitrated, with a tagged valid/ready response channel.
// Ports:   clk, rst (sync, active-high); bus (slave modport of pla_t4_eval_sched_if).
// Latency: response valid SETTLE_CYCLES+1 cycles after the grant cycle; held under backpressure.
module pla_t4_eval_sched #(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  pla_t4_eval_sched_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [11:0]    pla_x_q, pla_x_d;
  logic [7:0]     rsp_z_q, rsp_z_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic               win_vld;
  logic [IDW-1:0]     win_idx;
  logic [NUM_REQ-1:0] grant;
  int                 scan_idx;

  // Round-robin pick: scan from the highest offset down so the last hit
  // (the one closest to rr_ptr) is the one that sticks.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    grant    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (bus.req_valid[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = IDW'(scan_idx);
      end
    end
    // Reset masks the grant so nothing is offered while the block is being cleared.
    if (state_q == ST_IDLE && win_vld && !rst) begin
      grant[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    rsp_id_d    = rsp_id_q;
    cnt_d       = cnt_q;
    pla_x_d     = pla_x_q;
    rsp_z_d     = rsp_z_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          pla_x_d = bus.req_x[int'(win_idx)*12 +: 12];
          id_d    = win_idx;
          cnt_d   = 4'(SETTLE_CYCLES - 1);
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_z_d     = bus.pla_z;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        // rsp_valid is always set here, so rsp_ready alone completes the handshake.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      rsp_id_q    <= '0;
      cnt_q       <= '0;
      pla_x_q     <= '0;
      rsp_z_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      rsp_id_q    <= rsp_id_d;
      cnt_q       <= cnt_d;
      pla_x_q     <= pla_x_d;
      rsp_z_q     <= rsp_z_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.pla_x     = pla_x_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
